col_idct_seq: RTL and testbench
===============================

Name: col_idct_seq

Overview:
Column-pass sequencer for the 8x8 IDCT. After the row pass fills a 64-entry coefficient buffer, this block walks the 8 columns. For each column it reads 8 coefficients, drives the column-IDCT datapath in its permuted input order, and resets/releases the datapath. It then waits for the datapath ready flag and writes the 8 clipped pixels to the output pixel buffer. It sits between the row-IDCT buffer and the pixel/colour-conversion stage.

Parameters:
DATA_W, 32, coefficient and datapath word width (signed)
TIMEOUT, 63, maximum cycles spent in WAIT before aborting with error (fits 6-bit counter)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset; one clock; reset is synchronous and active-high
start  in  1  pulse: begin processing one block; ignored unless idle
busy  out  1  high from the cycle after accepted start until done/err
done  out  1  one-cycle pulse after the 64th pixel write
err  out  1  one-cycle pulse on WAIT timeout; block aborted
rd_en  out  1  coefficient buffer read strobe
rd_addr  out  6  coefficient address, row*8+col
rd_data  in  DATA_W  coefficient, valid 1 cycle after rd_en
idct_rst  out  1  datapath reset; high except in WAIT
idct_in  out  8*DATA_W  packed datapath inputs, slot k at bits [k*DATA_W +: DATA_W]
idct_y  in  8*DATA_W  packed datapath outputs y0..y7 (pixel = row index)
idct_rdy  in  1  datapath ready flag
wr_en  out  1  pixel buffer write strobe
wr_addr  out  6  pixel address, row*8+col
wr_data  out  8  pixel, low 8 bits of selected idct_y slot

Behaviour:
- Reset values: busy=0, done=0, err=0, rd_en=0, rd_addr=0, wr_en=0, wr_addr=0, wr_data=0, idct_rst=1, idct_in=0, col=0, state=IDLE.
- States: IDLE, LOAD, WAIT, STORE.
- IDLE: idct_rst=1. On start=1, go to LOAD, set col=0 and busy=1.
- LOAD: 9 cycles.
  - Cycles 0..7 assert rd_en with rd_addr=r*8+col, r=0..7.
  - Cycles 1..8 capture rd_data for row r-1 into its slot.
  - Row-to-slot map: row0->slot0, row4->slot1, row6->slot2, row2->slot3, row1->slot4, row7->slot5, row5->slot6, row3->slot7.
  - idct_rst=1 throughout. Then go to WAIT and clear the timeout counter.
- WAIT: idct_rst=0; idct_in held stable.
  - idct_rdy is sampled from the first WAIT cycle.
  - The datapath reset clears rdy, so a stale 1 cannot occur.
  - idct_rdy=1: capture idct_y into an output register, go to STORE.
  - Counter reaches TIMEOUT with rdy still 0: pulse err, busy=0, go to IDLE; no further writes.
- STORE: 8 cycles, idct_rst=1.
  - wr_en=1, wr_addr=r*8+col, wr_data=captured y_r[7:0], r=0..7.
  - On the last write: if col=7, pulse done, busy=0, go to IDLE; else col+1, go to LOAD.
- Per-column latency: 9 (LOAD) + W (WAIT, datapath dependent) + 8 (STORE).
- start while busy: ignored, no effect.
- start in the same cycle as done/err: ignored; the new start is accepted from IDLE next cycle.
- reset mid-operation: immediate return to reset values. The partial block is discarded; wr_en drops in the same cycle reset is sampled.
- wr_data takes only bits [7:0]; the datapath already clips to 0..255.
- rd_en and wr_en are never high together.

Decomposition:
- Shared idct package holds:
  - state enum {IDLE, LOAD, WAIT, STORE}
  - ROW_TO_SLOT constant array {0,4,6,2,1,7,5,3}, inverse as needed
  - BLK_DIM=8 and ADDR_W=6
- No sub-module. The datapath is instantiated by the parent and connected through the idct_* ports.

Test Plan:
- DC-only block: rd_data=64 at row0 of every column, 0 elsewhere, start -> 64 writes, all wr_data=129, done once, wr_addr order col-major r*8+c.
- Address/permutation: coefficient value = address (row*8+col) -> for col 3, idct_in slots 0..7 = {3,35,51,19,11,59,43,27} during WAIT.
- Datapath stub raising rdy 17 cycles after reset release -> each column takes 9+17+8 cycles; done at the expected total cycle count; no write outside STORE.
- Stub never raises rdy, TIMEOUT=63 -> err pulse after 63 WAIT cycles, busy=0, zero writes, idct_rst=1 afterwards.
- start pulsed during column 2 processing -> ignored; exactly 64 writes and one done.
- reset asserted during column 4 STORE -> wr_en=0 the next cycle, all outputs at reset values. A following start processes a full fresh block of 64 writes.

Source files
------------

// File: rtl/col_idct_seq_pkg.sv
// Shared definitions for the IDCT column-pass sequencer: state encoding,
// block geometry and the datapath input permutation.
package col_idct_seq_pkg;

  localparam int BLK_DIM = 8;
  localparam int ADDR_W  = 6;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    STORE
  } state_t;

  // Indexed by datapath slot: ROW_TO_SLOT[k] is the coefficient row fed into slot k.
  localparam logic [2:0] ROW_TO_SLOT [BLK_DIM] = '{3'd0, 3'd4, 3'd6, 3'd2, 3'd1, 3'd7, 3'd5, 3'd3};
  // Inverse view, indexed by coefficient row: the slot that row lands in.
  localparam logic [2:0] SLOT_OF_ROW [BLK_DIM] = '{3'd0, 3'd4, 3'd3, 3'd7, 3'd1, 3'd6, 3'd2, 3'd5};

endpackage

// File: rtl/col_idct_seq.sv
// Column-pass sequencer: reads each coefficient column in permuted order into
// the column-IDCT datapath, waits for its result and writes 8 pixels back.
module col_idct_seq
  import col_idct_seq_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 63
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output logic                o_rdEn,
  output logic [ADDR_W-1:0]   o_rdAddr,
  input  logic [DATA_W-1:0]   i_rdData,
  output logic                o_idctRst,
  output logic [8*DATA_W-1:0] o_idctIn,
  input  logic [8*DATA_W-1:0] i_idctY,
  input  logic                i_idctRdy,
  output logic                o_wrEn,
  output logic [ADDR_W-1:0]   o_wrAddr,
  output logic [7:0]          o_wrData
);

  localparam logic [5:0] TMO_LAST = 6'(TIMEOUT - 1);

  state_t                r_state;
  logic [2:0]            r_col;
  logic [3:0]            r_cnt;
  logic [5:0]            r_tmo;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic                  r_rdEn;
  logic [ADDR_W-1:0]     r_rdAddr;
  logic                  r_idctRst;
  logic [8*DATA_W-1:0]   r_idctIn;
  logic [8*DATA_W-1:0]   r_y;
  logic                  r_wrEn;
  logic [ADDR_W-1:0]     r_wrAddr;
  logic [7:0]            r_wrData;

  logic [2:0]            w_nextRow;
  logic [2:0]            w_prevRow;

  assign w_nextRow = r_cnt[2:0] + 3'd1;
  assign w_prevRow = r_cnt[2:0] - 3'd1;

  // All outputs are registered; each state prepares the strobes for the following cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_col     <= 3'd0;
      r_cnt     <= 4'd0;
      r_tmo     <= 6'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rdEn    <= 1'b0;
      r_rdAddr  <= '0;
      r_idctRst <= 1'b1;
      r_idctIn  <= '0;
      r_y       <= '0;
      r_wrEn    <= 1'b0;
      r_wrAddr  <= '0;
      r_wrData  <= 8'd0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          // A start coinciding with the done/err pulse is dropped.
          if (i_start && !r_done && !r_err) begin
            r_state  <= LOAD;
            r_col    <= 3'd0;
            r_cnt    <= 4'd0;
            r_busy   <= 1'b1;
            r_rdEn   <= 1'b1;
            r_rdAddr <= '0;
          end
        end
        LOAD: begin
          // Read data lags the strobe by one cycle, so count c captures row c-1.
          if (r_cnt != 4'd0)
            r_idctIn[int'(SLOT_OF_ROW[w_prevRow])*DATA_W +: DATA_W] <= i_rdData;
          if (r_cnt == 4'd8) begin
            r_state   <= WAIT;
            r_tmo     <= 6'd0;
            r_idctRst <= 1'b0;
          end else begin
            r_cnt    <= r_cnt + 4'd1;
            r_rdEn   <= (r_cnt != 4'd7);
            r_rdAddr <= {w_nextRow, r_col};
          end
        end
        WAIT: begin
          if (i_idctRdy) begin
            r_state   <= STORE;
            r_idctRst <= 1'b1;
            r_y       <= i_idctY;
            r_cnt     <= 4'd0;
            r_wrEn    <= 1'b1;
            r_wrAddr  <= {3'd0, r_col};
            r_wrData  <= i_idctY[7:0];
          end else if (r_tmo == TMO_LAST) begin
            r_state   <= IDLE;
            r_idctRst <= 1'b1;
            r_err     <= 1'b1;
            r_busy    <= 1'b0;
          end else begin
            r_tmo <= r_tmo + 6'd1;
          end
        end
        STORE: begin
          if (r_cnt == 4'd7) begin
            r_wrEn <= 1'b0;
            if (r_col == 3'd7) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_col    <= r_col + 3'd1;
              r_state  <= LOAD;
              r_cnt    <= 4'd0;
              r_rdEn   <= 1'b1;
              r_rdAddr <= {3'd0, r_col + 3'd1};
            end
          end else begin
            r_cnt    <= r_cnt + 4'd1;
            r_wrAddr <= {w_nextRow, r_col};
            r_wrData <= r_y[int'(w_nextRow)*DATA_W +: 8];
          end
        end
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_err     = r_err;
  assign o_rdEn    = r_rdEn;
  assign o_rdAddr  = r_rdAddr;
  assign o_idctRst = r_idctRst;
  assign o_idctIn  = r_idctIn;
  assign o_wrEn    = r_wrEn;
  assign o_wrAddr  = r_wrAddr;
  assign o_wrData  = r_wrData;

endmodule

// File: tb/tb_col_idct_seq.sv
// Self-checking bench for col_idct_seq: coefficient buffer model, datapath stub
// with fixed latency, and a scoreboard of expected pixel writes.
module tb_col_idct_seq;

  localparam int DATA_W       = 32;
  localparam int TIMEOUT      = 63;
  localparam int STUB_LAT     = 17;
  localparam int COL_CYCLES   = 9 + STUB_LAT + 8;
  localparam int BLOCK_CYCLES = 8 * COL_CYCLES;

  typedef struct {
    logic [5:0] addr;
    logic [7:0] data;
  } wr_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic                busy, done, err;
  logic                rdEn;
  logic [5:0]          rdAddr;
  logic [DATA_W-1:0]   rdData = '0;
  logic                idctRst;
  logic [8*DATA_W-1:0] idctIn;
  logic [8*DATA_W-1:0] idctY;
  logic                idctRdy;
  logic                wrEn;
  logic [5:0]          wrAddr;
  logic [7:0]          wrData;

  logic [DATA_W-1:0]   mem [64];
  int                  slotRow [8] = '{0, 4, 6, 2, 1, 7, 5, 3};
  wr_t                 expQ [$];
  wr_t                 e;
  int                  stubCnt = 0;
  bit                  stubNever = 1'b0;
  int                  vectors = 0;
  int                  miscompares = 0;
  int                  writeCount = 0;
  int                  doneCount = 0;

  col_idct_seq #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_start   (start),
    .o_busy    (busy),
    .o_done    (done),
    .o_err     (err),
    .o_rdEn    (rdEn),
    .o_rdAddr  (rdAddr),
    .i_rdData  (rdData),
    .o_idctRst (idctRst),
    .o_idctIn  (idctIn),
    .i_idctY   (idctY),
    .i_idctRdy (idctRdy),
    .o_wrEn    (wrEn),
    .o_wrAddr  (wrAddr),
    .o_wrData  (wrData)
  );

  always #5 clk = ~clk;

  // Coefficient buffer with one cycle read latency.
  always @(posedge clk) begin
    if (rdEn) rdData <= mem[rdAddr];
  end

  // Datapath stub: rdy in the STUB_LAT-th cycle after its reset is released.
  always @(posedge clk) begin
    if (idctRst) stubCnt <= 0;
    else         stubCnt <= stubCnt + 1;
  end

  assign idctRdy = !stubNever && !idctRst && (stubCnt == STUB_LAT - 1);

  always_comb begin
    logic [31:0] sum;
    sum   = '0;
    idctY = '0;
    for (int k = 0; k < 8; k++) sum = sum + idctIn[k*DATA_W +: DATA_W];
    for (int r = 0; r < 8; r++)
      idctY[r*DATA_W +: DATA_W] = 2 * sum + 32'd1 + 32'(r) * idctIn[r*DATA_W +: DATA_W];
  end

  // Write monitor: every pixel write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (wrEn) begin
      writeCount++;
      vectors++;
      if (expQ.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_write addr=%0d data=%0d, no write expected", wrAddr, wrData);
      end else begin
        e = expQ.pop_front();
        if (wrAddr !== e.addr || wrData !== e.data) begin
          miscompares++;
          $display("[TB] FAIL pixel_write got addr=%0d data=%0d, want addr=%0d data=%0d",
                   wrAddr, wrData, e.addr, e.data);
        end
      end
      if (rdEn) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL rd_wr_overlap got rd_en=%0b wr_en=%0b, want not both", rdEn, wrEn);
      end
    end
    if (done) doneCount++;
  end

  // Expected writes for the current buffer contents, column-major.
  task automatic pushBlock();
    logic [31:0] in [8];
    logic [31:0] sum;
    logic [31:0] y;
    wr_t         w;
    for (int c = 0; c < 8; c++) begin
      sum = '0;
      for (int k = 0; k < 8; k++) begin
        in[k] = mem[slotRow[k] * 8 + c];
        sum   = sum + in[k];
      end
      for (int r = 0; r < 8; r++) begin
        y      = 2 * sum + 32'd1 + 32'(r) * in[r];
        w.addr = 6'(r * 8 + c);
        w.data = y[7:0];
        expQ.push_back(w);
      end
    end
  endtask

  task automatic fillRandom();
    for (int a = 0; a < 64; a++) mem[a] = $urandom;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    vectors += 4;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_status got busy=%0b done=%0b err=%0b, want 0 0 0", busy, done, err);
    end
    if (rdEn !== 1'b0 || rdAddr !== 6'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_read got rd_en=%0b rd_addr=%0d, want 0 0", rdEn, rdAddr);
    end
    if (wrEn !== 1'b0 || wrAddr !== 6'd0 || wrData !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_write got wr_en=%0b addr=%0d data=%0d, want 0 0 0", wrEn, wrAddr, wrData);
    end
    if (idctRst !== 1'b1 || idctIn !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_datapath got idct_rst=%0b idct_in=%0h, want 1 0", idctRst, idctIn);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_dc_block();
    int cycles;
    int w0, d0;
    for (int a = 0; a < 64; a++) mem[a] = (a < 8) ? 32'd64 : 32'd0;
    pushBlock();
    w0 = writeCount;
    d0 = doneCount;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL busy_after_start got %0b, want 1", busy);
    end
    cycles = 0;
    while (!done && cycles < 2000) begin
      @(negedge clk);
      cycles++;
    end
    vectors += 2;
    if (cycles != BLOCK_CYCLES) begin
      miscompares++;
      $display("[TB] FAIL dc_done_cycle got %0d, want %0d", cycles, BLOCK_CYCLES);
    end
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL dc_busy_at_done got %0b, want 0", busy);
    end
    @(negedge clk);
    vectors += 3;
    if (done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL dc_done_width got %0b, want 0", done);
    end
    if (writeCount - w0 != 64) begin
      miscompares++;
      $display("[TB] FAIL dc_write_count got %0d, want 64", writeCount - w0);
    end
    if (doneCount - d0 != 1) begin
      miscompares++;
      $display("[TB] FAIL dc_done_count got %0d, want 1", doneCount - d0);
    end
  endtask

  task automatic test_permutation();
    int  n;
    int  waitEntries;
    bit  prevRst;
    logic [31:0] want;
    for (int a = 0; a < 64; a++) mem[a] = 32'(a);
    pushBlock();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    waitEntries = 0;
    prevRst = 1'b1;
    while (waitEntries < 4 && n < 2000) begin
      @(negedge clk);
      n++;
      if (prevRst && !idctRst) waitEntries++;
      prevRst = idctRst;
    end
    vectors++;
    if (waitEntries != 4) begin
      miscompares++;
      $display("[TB] FAIL perm_col3_wait got %0d wait entries, want 4", waitEntries);
    end
    for (int k = 0; k < 8; k++) begin
      want = 32'(slotRow[k] * 8 + 3);
      vectors++;
      if (idctIn[k*DATA_W +: DATA_W] !== want) begin
        miscompares++;
        $display("[TB] FAIL perm_slot%0d got %0d, want %0d", k, idctIn[k*DATA_W +: DATA_W], want);
      end
    end
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL perm_done got %0b, want 1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int n;
    int waitCycles;
    int w0;
    stubNever = 1'b1;
    w0 = writeCount;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    waitCycles = 0;
    while (!err && n < 500) begin
      @(negedge clk);
      n++;
      if (!idctRst) waitCycles++;
    end
    vectors += 3;
    if (err !== 1'b1 || waitCycles != TIMEOUT) begin
      miscompares++;
      $display("[TB] FAIL timeout_wait got err=%0b wait_cycles=%0d, want 1 %0d", err, waitCycles, TIMEOUT);
    end
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL timeout_busy got %0b, want 0", busy);
    end
    if (writeCount != w0) begin
      miscompares++;
      $display("[TB] FAIL timeout_writes got %0d, want 0", writeCount - w0);
    end
    @(negedge clk);
    vectors++;
    if (err !== 1'b0 || idctRst !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL timeout_after got err=%0b idct_rst=%0b busy=%0b, want 0 1 0", err, idctRst, busy);
    end
    stubNever = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cycles;
    int w0, d0;
    fillRandom();
    pushBlock();
    w0 = writeCount;
    d0 = doneCount;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (!done && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      start = (cycles == 2 * COL_CYCLES + 12);
    end
    vectors++;
    if (cycles != BLOCK_CYCLES) begin
      miscompares++;
      $display("[TB] FAIL busy_start_done_cycle got %0d, want %0d", cycles, BLOCK_CYCLES);
    end
    // Start raised in the same cycle as done must be dropped.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL start_on_done got busy=%0b, want 0", busy);
    end
    repeat (3) @(negedge clk);
    vectors += 2;
    if (writeCount - w0 != 64) begin
      miscompares++;
      $display("[TB] FAIL busy_start_writes got %0d, want 64", writeCount - w0);
    end
    if (doneCount - d0 != 1 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL busy_start_done_count got %0d busy=%0b, want 1 0", doneCount - d0, busy);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int w0;
    fillRandom();
    pushBlock();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(wrEn && wrAddr == 6'd20) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!(wrEn === 1'b1 && wrAddr === 6'd20)) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_reach got wr_en=%0b addr=%0d, want 1 20", wrEn, wrAddr);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors += 3;
    if (wrEn !== 1'b0 || wrAddr !== 6'd0 || wrData !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_write got wr_en=%0b addr=%0d data=%0d, want 0 0 0", wrEn, wrAddr, wrData);
    end
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || rdEn !== 1'b0 || rdAddr !== 6'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_ctrl got busy=%0b done=%0b err=%0b rd_en=%0b rd_addr=%0d, want 0 0 0 0 0",
               busy, done, err, rdEn, rdAddr);
    end
    if (idctRst !== 1'b1 || idctIn !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_datapath got idct_rst=%0b idct_in=%0h, want 1 0", idctRst, idctIn);
    end
    reset = 1'b0;
    expQ.delete();
    @(negedge clk);
    fillRandom();
    pushBlock();
    w0 = writeCount;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    vectors += 2;
    if (n != BLOCK_CYCLES) begin
      miscompares++;
      $display("[TB] FAIL fresh_block_cycle got %0d, want %0d", n, BLOCK_CYCLES);
    end
    if (writeCount - w0 != 64) begin
      miscompares++;
      $display("[TB] FAIL fresh_block_writes got %0d, want 64", writeCount - w0);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int a = 0; a < 64; a++) mem[a] = '0;
    test_reset();
    test_dc_block();
    test_permutation();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL leftover_expected got %0d pending writes, want 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
